channel_select_seq: RTL

//  Parametrised registered selector for result-driving sources (dice, traffic lights, counters).

---
 rtl/chsel_pkg.sv | 11 +
 rtl/dwell_timer.sv | 65 ++++++
 rtl/channel_select_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/chsel_pkg.sv
// Shared encodings for the channel selector: mode codes and FSM states.
package chsel_pkg;
  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_FREEZE = 2'b10;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_e;
endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for auto-rotate plus search for the next valid channel above
// the one currently shown (wrapping), excluding the shown channel itself.
module dwell_timer
  import chsel_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DWELL    = 8,
  localparam int SEL_W   = $clog2(CHANNELS),
  localparam int CNT_W   = $clog2(DWELL + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                inc_i,
  input  logic [SEL_W-1:0]    active_ch_i,
  input  logic [CHANNELS-1:0] ch_valid_i,
  output logic                expire_o,
  output logic                advance_o,
  output logic [SEL_W-1:0]    next_ch_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             found;
  int               idx;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CNT_W'(DWELL - 1));

  // Nearest valid channel walking upward from the shown one; the shown
  // channel is never a candidate, so "none found" means stay.
  always_comb begin
    found     = 1'b0;
    next_ch_o = active_ch_i;
    idx       = 0;
    for (int i = 1; i < CHANNELS; i++) begin
      idx = int'(active_ch_i) + i;
      if (idx >= CHANNELS) begin
        idx = idx - CHANNELS;
      end
      if (!found && ch_valid_i[SEL_W'(idx)]) begin
        found     = 1'b1;
        next_ch_o = SEL_W'(idx);
      end
    end
  end

  assign advance_o = expire_o && found;

endmodule

// File: rtl/channel_select_seq.sv
// Registered channel selector with manual / auto-rotate / freeze modes and
// zero-output blanking cycles on every channel change.
module channel_select_seq
  import chsel_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 2,
  parameter int DWELL    = 8,
  parameter int BLANK    = 1,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] ch_data,
  input  logic [CHANNELS-1:0]       ch_valid,
  output logic [WIDTH-1:0]          result,
  output logic                      result_valid,
  output logic [SEL_W-1:0]          active_ch,
  output logic                      switching
);

  localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] active_q, active_d;
  logic [SEL_W-1:0] target_q, target_d;
  logic [BW-1:0]    blank_q, blank_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             switching_q, switching_d;

  logic             cnt_clr, cnt_inc;
  logic             expire, advance;
  logic [SEL_W-1:0] next_ch;
  logic             chg;
  logic [SEL_W-1:0] chg_ch;

  logic [WIDTH-1:0] ch_arr [CHANNELS];

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
    assign ch_arr[gi] = ch_data[gi*WIDTH +: WIDTH];
  end

  dwell_timer #(
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) u_dwell_timer (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (cnt_clr),
    .inc_i       (cnt_inc),
    .active_ch_i (active_q),
    .ch_valid_i  (ch_valid),
    .expire_o    (expire),
    .advance_o   (advance),
    .next_ch_o   (next_ch)
  );

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    target_d    = target_q;
    blank_d     = blank_q;
    result_d    = result_q;
    valid_d     = valid_q;
    switching_d = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    chg         = 1'b0;
    chg_ch      = active_q;

    case (state_q)
      ST_SHOW: begin
        if (mode == MODE_FREEZE) begin
          result_d = result_q;
        end else if (mode == MODE_AUTO) begin
          if (advance) begin
            chg    = 1'b1;
            chg_ch = next_ch;
          end else begin
            cnt_clr  = expire;
            cnt_inc  = !expire;
            result_d = ch_arr[active_q];
            valid_d  = ch_valid[active_q];
          end
        end else begin
          // Manual (and the 11 alias) keeps the dwell count parked at zero so
          // a later switch to auto starts a fresh dwell.
          cnt_clr = 1'b1;
          if ((int'(sel) < CHANNELS) && (sel != active_q)) begin
            chg    = 1'b1;
            chg_ch = sel;
          end else begin
            result_d = ch_arr[active_q];
            valid_d  = ch_valid[active_q];
          end
        end

        if (chg) begin
          cnt_clr = 1'b1;
          if (BLANK == 0) begin
            active_d = chg_ch;
            result_d = ch_arr[chg_ch];
            valid_d  = ch_valid[chg_ch];
          end else begin
            state_d     = ST_BLANK;
            target_d    = chg_ch;
            blank_d     = '0;
            result_d    = '0;
            valid_d     = 1'b0;
            switching_d = 1'b1;
          end
        end
      end

      ST_BLANK: begin
        cnt_clr = 1'b1;
        if (blank_q == BW'(BLANK - 1)) begin
          state_d  = ST_SHOW;
          active_d = target_q;
          result_d = ch_arr[target_q];
          valid_d  = ch_valid[target_q];
        end else begin
          blank_d     = blank_q + BW'(1);
          switching_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_SHOW;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_SHOW;
      active_q    <= '0;
      target_q    <= '0;
      blank_q     <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      switching_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      target_q    <= target_d;
      blank_q     <= blank_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      switching_q <= switching_d;
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;
  assign active_ch    = active_q;
  assign switching    = switching_q;

endmodule
